// File: rtl/uart_pkg.sv
// Shared types and register map for the UART receive port.
// Holds the receiver FSM states, register offsets and STATUS bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [9:0] UART_DATA_OFS   = 10'h000;
    localparam logic [9:0] UART_STATUS_OFS = 10'h001;

    localparam int STAT_EMPTY_BIT   = 0;
    localparam int STAT_FULL_BIT    = 1;
    localparam int STAT_OVERRUN_BIT = 2;
    localparam int STAT_FRAMING_BIT = 3;
    localparam int STAT_COUNT_LSB   = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with power-of-two depth and an occupancy count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_read_port.sv
// 8N1 UART receiver feeding a FIFO, exposed to the CPU as a DATA/STATUS register pair.
// Read data is combinational; side effects happen only on the first cycle of a strobe.
module uart_read_port
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    input  logic        uart_MR_i,
    input  logic [9:0]  uart_address_i,
    output logic [31:0] uart_data_o,
    output logic        rx_avail_o,
    output rx_state_e   dbg_state
);
    localparam int CNT_W   = $clog2(CLKS_PER_BIT) + 1;
    localparam int FIFO_CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    rx_state_e         state, state_n;
    logic [CNT_W-1:0]  clk_cnt, clk_cnt_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [7:0]        shift, shift_n;
    logic              rx_meta, rx_sync, rx_sync_d;
    logic              rx_fall;
    logic              rx_push, frame_err_set;

    logic              mr_prev, rd_first;
    logic              pop, stat_clr;
    logic              overrun, framing_err;
    logic [7:0]        fifo_dout;
    logic              fifo_empty, fifo_full;
    logic [FIFO_CW-1:0] fifo_count;
    logic [31:0]       status_word;

    assign dbg_state = state;
    assign rx_fall   = rx_sync_d & ~rx_sync;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_sync_d <= 1'b1;
        end else begin
            rx_meta   <= rx_i;
            rx_sync   <= rx_meta;
            rx_sync_d <= rx_sync;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n       = state;
        clk_cnt_n     = clk_cnt;
        bit_cnt_n     = bit_cnt;
        shift_n       = shift;
        rx_push       = 1'b0;
        frame_err_set = 1'b0;
        case (state)
            IDLE: begin
                if (rx_fall) begin
                    state_n   = START;
                    clk_cnt_n = '0;
                    bit_cnt_n = '0;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (clk_cnt == HALF_CNT) begin
                    clk_cnt_n = '0;
                    state_n   = rx_sync ? IDLE : DATA;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt == LAST_CNT) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_sync, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = STOP;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (clk_cnt == LAST_CNT) begin
                    clk_cnt_n     = '0;
                    rx_push       = rx_sync;
                    frame_err_set = ~rx_sync;
                    state_n       = IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (rx_push),
        .pop   (pop),
        .din   (shift),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Read handshake: uart_MR_i has no ready/ack; data is valid combinationally
    // while it is high, and only its rising cycle may pop or clear flags.
    assign rd_first = uart_MR_i & ~mr_prev;
    assign pop      = rd_first & (uart_address_i == UART_DATA_OFS) & ~fifo_empty;
    assign stat_clr = rd_first & (uart_address_i == UART_STATUS_OFS);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mr_prev     <= 1'b0;
            overrun     <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            mr_prev     <= uart_MR_i;
            overrun     <= (overrun & ~stat_clr) | (rx_push & fifo_full & ~pop);
            framing_err <= (framing_err & ~stat_clr) | frame_err_set;
        end
    end

    always_comb begin
        status_word                   = '0;
        status_word[STAT_EMPTY_BIT]   = fifo_empty;
        status_word[STAT_FULL_BIT]    = fifo_full;
        status_word[STAT_OVERRUN_BIT] = overrun;
        status_word[STAT_FRAMING_BIT] = framing_err;
        status_word[STAT_COUNT_LSB +: FIFO_CW] = fifo_count;
    end

    always_comb begin
        uart_data_o = '0;
        case (uart_address_i)
            UART_DATA_OFS:   uart_data_o = fifo_empty ? 32'b0 : {24'b0, fifo_dout};
            UART_STATUS_OFS: uart_data_o = status_word;
            default:         uart_data_o = '0;
        endcase
    end

    assign rx_avail_o = ~fifo_empty;

endmodule

// File: tb/tb_uart_read_port.sv
// Scoreboard bench for uart_read_port: reads push {rx_avail, data} expectations,
// a negedge monitor compares them on the first cycle of each read strobe.
module tb_uart_read_port;
    import uart_pkg::*;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx;
    logic        mr;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        avail;
    rx_state_e   dbg_state;

    int checks = 0;
    int errors = 0;

    logic [32:0] exp_q[$];
    logic [9:0]  addr_q[$];

    logic        probe_on = 1'b0;
    int          probe_kind = 0;
    logic [31:0] probe_exp = '0;

    always #5 clk = ~clk;

    uart_read_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .rx_i           (rx),
        .uart_MR_i      (mr),
        .uart_address_i (addr),
        .uart_data_o    (data),
        .rx_avail_o     (avail),
        .dbg_state      (dbg_state)
    );

    // Monitor: all comparisons happen here, away from the rising edge.
    logic        mon_prev = 1'b0;
    logic [32:0] mon_e;
    logic [9:0]  mon_a;
    logic [31:0] mon_got;
    always @(negedge clk) begin
        if (mr && !mon_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected addr=%h got avail=%b data=%h", addr, avail, data);
            end else begin
                mon_e = exp_q.pop_front();
                mon_a = addr_q.pop_front();
                if ({avail, data} !== mon_e || addr !== mon_a) begin
                    errors++;
                    $display("FAIL read@%h got avail=%b data=%h exp avail=%b data=%h",
                             mon_a, avail, data, mon_e[32], mon_e[31:0]);
                end
            end
        end
        mon_prev = mr;
        if (probe_on) begin
            checks++;
            case (probe_kind)
                0:       mon_got = 32'(dbg_state);
                2:       mon_got = 32'(exp_q.size());
                default: mon_got = 32'hFFFF_FFFF;
            endcase
            if (mon_got !== probe_exp) begin
                errors++;
                $display("FAIL probe kind=%0d got %h exp %h", probe_kind, mon_got, probe_exp);
            end
        end
    end

    task automatic probe(input int kind, input logic [31:0] e);
        probe_kind = kind;
        probe_exp  = e;
        @(posedge clk); #1 probe_on = 1'b1;
        @(posedge clk); #1 probe_on = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [32:0] e, input int hold);
        exp_q.push_back(e);
        addr_q.push_back(a);
        @(posedge clk); #1 addr = a; mr = 1'b1;
        repeat (hold) @(posedge clk);
        #1 mr = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (CPB) @(posedge clk);
        #1 rx = stop_bit;
        repeat (CPB) @(posedge clk);
        #1 rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic wait_state(input rx_state_e s);
        bit ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (dbg_state == s) ok = 1'b1;
        end
        if (!ok) probe(1, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rx = 1'b1; mr = 1'b0; addr = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and unmapped offsets
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0001}, 1);
        rd(UART_DATA_OFS,   {1'b0, 32'h0}, 1);
        rd(10'h3FF,         {1'b0, 32'h0}, 1);
        probe(0, 32'(IDLE));

        // Single byte
        send_byte(8'hA5, 1'b1);
        rd(UART_STATUS_OFS, {1'b1, 32'h0000_0010}, 1);
        rd(UART_DATA_OFS,   {1'b1, 32'h0000_00A5}, 1);
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0001}, 1);

        // Held strobe pops once; other offsets have no side effect
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        rd(UART_STATUS_OFS, {1'b1, 32'h0000_0020}, 1);
        rd(10'h004,         {1'b1, 32'h0}, 1);
        rd(UART_DATA_OFS,   {1'b1, 32'h0000_0011}, 5);
        rd(UART_DATA_OFS,   {1'b1, 32'h0000_0022}, 1);
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0001}, 1);

        // Overflow: 17 bytes, the last is dropped
        for (int i = 0; i < 17; i++) send_byte(8'(8'h30 + i), 1'b1);
        rd(UART_STATUS_OFS, {1'b1, 32'h0000_0106}, 1);
        rd(UART_STATUS_OFS, {1'b1, 32'h0000_0102}, 1);

        // Pop coinciding with the stop-bit push while full
        fork
            send_byte(8'h99, 1'b1);
            begin
                wait_state(STOP);
                repeat (CPB - 1) @(posedge clk);
                exp_q.push_back({1'b1, 32'h0000_0030});
                addr_q.push_back(UART_DATA_OFS);
                #1 addr = UART_DATA_OFS; mr = 1'b1;
                @(posedge clk); #1 mr = 1'b0;
            end
        join
        rd(UART_STATUS_OFS, {1'b1, 32'h0000_0102}, 1);
        for (int i = 1; i < 16; i++) rd(UART_DATA_OFS, {1'b1, 32'(8'h30 + i)}, 1);
        rd(UART_DATA_OFS,   {1'b1, 32'h0000_0099}, 1);
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0001}, 1);
        rd(UART_DATA_OFS,   {1'b0, 32'h0}, 1);

        // Framing error
        send_byte(8'h5A, 1'b0);
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0009}, 1);
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0001}, 1);

        // Short glitch is rejected
        @(posedge clk); #1 rx = 1'b0;
        repeat (2) @(posedge clk); #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        probe(0, 32'(IDLE));
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0001}, 1);

        // Reset in the middle of a frame
        @(posedge clk); #1 rx = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        probe(0, 32'(DATA));
        rst = 1'b1; rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (20) @(posedge clk);
        probe(0, 32'(IDLE));
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0001}, 1);
        rd(UART_DATA_OFS,   {1'b0, 32'h0}, 1);
        send_byte(8'h3C, 1'b1);
        rd(UART_DATA_OFS,   {1'b1, 32'h0000_003C}, 1);
        rd(UART_STATUS_OFS, {1'b0, 32'h0000_0001}, 1);

        // Every queued expectation must have been consumed
        probe(2, 32'h0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_read_port.md
UART_READ_PORT -- requirements
Module: uart_read_port

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud).
REQ-002 Parameter FIFO_DEPTH, default 16, receive FIFO entries (power of two).
REQ-003 clk_i  input  1  system clock; single clock domain, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 rx_i  input  1  asynchronous serial line, idle high, 8N1 frames.
REQ-006 uart_MR_i  input  1  memory-read strobe from the CPU-side address decoder.
REQ-007 uart_address_i  input  10  register offset within the UART window.
REQ-008 uart_data_o  output  32  combinational read data for the current uart_address_i.
REQ-009 rx_avail_o  output  1  high while FIFO is non-empty.

Function
REQ-010 rx_i SHALL pass through a 2-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-011 Receiver FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on synchronized rx high-to-low; bit counter and clock counter cleared.
REQ-013 START: at count CLKS_PER_BIT/2 (integer division), rx low -> DATA with counter reset; rx high -> IDLE (false start, nothing recorded).
REQ-014 DATA: sample rx every CLKS_PER_BIT cycles, shift in LSB first; after 8th sample -> STOP.
REQ-015 STOP: sample after CLKS_PER_BIT cycles; rx high -> push byte, rx low -> discard byte and set framing_err; both -> IDLE.
REQ-016 Push when FIFO full SHALL drop the byte and set overrun; FIFO contents unchanged.
REQ-017 Offset 0x000 (DATA): uart_data_o = {24'b0, FIFO head}; 32'b0 when empty.
REQ-018 Offset 0x001 (STATUS): bit0 empty, bit1 full, bit2 overrun, bit3 framing_err, bits[8:4] count (0..FIFO_DEPTH), others 0.
REQ-019 All other offsets SHALL read 32'b0 with no side effects.
REQ-020 Side effects SHALL occur only on the first cycle of a read (uart_MR_i high now, low the previous cycle); holding uart_MR_i high causes exactly one side effect.
REQ-021 DATA read side effect: pop one entry if non-empty; no action when empty.
REQ-022 STATUS read side effect: clear overrun and framing_err at that clock edge; the returned value shows the pre-clear flags.
REQ-023 Simultaneous push and pop: both take effect; count unchanged; when full, no overrun.
REQ-024 A flag set and cleared in the same cycle SHALL end set.
REQ-025 Read data SHALL be valid in the same cycle as address/strobe (zero latency); a pop becomes visible the following cycle.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-027 On rst_i: FSM IDLE, counters 0, shift register 0, FIFO empty (pointers 0, count 0), overrun 0, framing_err 0, previous-strobe register 0.
REQ-028 Reset mid-frame SHALL abandon the frame; no partial byte is pushed.
REQ-029 After reset: uart_data_o = 32'h0000_0001 at offset 1, 32'b0 at offset 0; rx_avail_o = 0.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, register offsets (UART_DATA_OFS, UART_STATUS_OFS) and status bit positions.
REQ-031 FIFO SHALL be a sub-module uart_rx_fifo (push, pop, din, dout, empty, full, count); the FSM and register decode live in uart_read_port.

Verification
REQ-032 Send 0xA5 at CLKS_PER_BIT=8, then read offset 0 for one cycle -> data 32'h0000_00A5; next cycle status shows empty=1, count=0.
REQ-033 Hold uart_MR_i high for 5 cycles at offset 0 with bytes 0x11, 0x22 queued -> exactly one pop; offset 0 then shows 0x22.
REQ-034 Send 17 bytes with no reads -> status full=1, overrun=1, count=16; status read clears overrun; bytes 1..16 read back in order.
REQ-035 Frame with stop bit 0 -> nothing pushed, framing_err=1; a 2-cycle low glitch on rx_i -> FSM back to IDLE, no flags.
REQ-036 FIFO full, DATA read coinciding with the STOP-bit push -> count stays 16, overrun=0, new byte at tail.
REQ-037 Assert rst_i during the DATA state -> after release, FIFO empty, flags 0, next clean frame received correctly.
